mem_wb_pipe_reg: RTL and testbench

Parametrised successor to the fixed MEM/WB register.
- Elastic valid/ready MEM→WB stage with a 2-entry skid buffer, so a regfile-port stall does not stall MEM combinationally.
- Computes the final writeback value inside the stage: result select, load byte/half extraction with sign/zero extension, x0 write suppression.
- Sits between the data-memory stage and the register file.

---
 rtl/mem_wb_pipe_reg.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_wb_pipe_reg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: elastic MEM->WB stage with a 2-entry skid buffer.
// Forms the final writeback value at capture time:
//   - result select
//   - load byte/half extraction with sign/zero extension
//   - x0 write suppression
// mem_ready_o comes straight from a flop, so a regfile stall never reaches
// MEM combinationally.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush_i             drop both entries
//   mem_* (in)          upstream entry: valid, alu result, read word, pc+4, rd,
//                       reg write, result select, load funct3
//   mem_ready_o         stage can accept (registered, equals ~skid valid)
//   wb_ready_i          regfile accepts this cycle
//   wb_* (out)          valid, rd, qualified write enable, write data
//
// Optional feature macro MEM_WB_PERF_CNT_EN adds:
//   perf_stall_cnt_o    cycles with wb_valid_o & ~wb_ready_i
//   perf_flush_cnt_o    valid entries discarded by flush
module mem_wb_pipe_reg #(
  parameter int unsigned XLEN               = 32,
  parameter int unsigned REG_ADDR_W         = 5,
  parameter bit          RESERVED_SEL_WRITE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic [XLEN-1:0]       mem_alu_result_i,
  input  logic [XLEN-1:0]       mem_mem_read_data_i,
  input  logic [XLEN-1:0]       mem_pc_plus_4_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr_i,
  input  logic                  mem_reg_write_en_i,
  input  logic [1:0]            mem_mem_to_reg_i,
  input  logic [2:0]            mem_load_funct3_i,
  input  logic                  wb_ready_i,
  output logic                  wb_valid_o,
  output logic [REG_ADDR_W-1:0] wb_rd_addr_o,
  output logic                  wb_reg_write_en_o,
  output logic [XLEN-1:0]       wb_write_data_o
`ifdef MEM_WB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt_o,
  output logic [31:0]           perf_flush_cnt_o
`endif
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;

  // Output entry
  logic                  out_valid_q, out_valid_d;
  logic [REG_ADDR_W-1:0] out_rd_q, out_rd_d;
  logic                  out_wen_q, out_wen_d;
  logic [XLEN-1:0]       out_data_q, out_data_d;

  // Skid entry
  logic                  skid_valid_q, skid_valid_d;
  logic [REG_ADDR_W-1:0] skid_rd_q, skid_rd_d;
  logic                  skid_wen_q, skid_wen_d;
  logic [XLEN-1:0]       skid_data_q, skid_data_d;

  logic                  ready_q, ready_d;

`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
`endif

  // Captured-entry formation
  logic [WORD_W-1:0] word_c;
  logic [BYTE_W-1:0] byte_c;
  logic [HALF_W-1:0] half_c;
  logic [XLEN-1:0]   load_c;
  logic [XLEN-1:0]   cap_data_c;
  logic              cap_allow_c;
  logic              cap_wen_c;

  // Writeback value and qualified write enable for the incoming entry
  always_comb begin
    word_c      = mem_mem_read_data_i[WORD_W-1:0];
    byte_c      = word_c[{mem_alu_result_i[1:0], 3'b000} +: BYTE_W];
    half_c      = mem_alu_result_i[1] ? word_c[WORD_W-1:HALF_W] : word_c[HALF_W-1:0];
    load_c      = XLEN'(word_c);
    cap_data_c  = mem_alu_result_i;
    cap_allow_c = 1'b1;
    case (mem_load_funct3_i)
      3'b000:  load_c = {{(XLEN-BYTE_W){byte_c[BYTE_W-1]}}, byte_c};
      3'b001:  load_c = {{(XLEN-HALF_W){half_c[HALF_W-1]}}, half_c};
      3'b100:  load_c = XLEN'(byte_c);
      3'b101:  load_c = XLEN'(half_c);
      default: load_c = XLEN'(word_c);
    endcase
    case (mem_mem_to_reg_i)
      2'b00: cap_data_c = mem_alu_result_i;
      2'b01: cap_data_c = load_c;
      2'b10: cap_data_c = mem_pc_plus_4_i;
      default: begin
        // Reserved select: either behaves like ALU or squashes the write
        if (RESERVED_SEL_WRITE) begin
          cap_data_c = mem_alu_result_i;
        end else begin
          cap_data_c  = '0;
          cap_allow_c = 1'b0;
        end
      end
    endcase
    cap_wen_c = mem_reg_write_en_i & (mem_rd_addr_i != '0) & cap_allow_c;
  end

  logic in_xfer_c;
  logic out_free_c;

  // Entry movement between input, skid and output
  always_comb begin
    out_valid_d  = out_valid_q;
    out_rd_d     = out_rd_q;
    out_wen_d    = out_wen_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_rd_d    = skid_rd_q;
    skid_wen_d   = skid_wen_q;
    skid_data_d  = skid_data_q;

    in_xfer_c  = mem_valid_i & ready_q;
    out_free_c = ~out_valid_q | wb_ready_i;

    if (flush_i) begin
      out_valid_d  = 1'b0;
      out_rd_d     = '0;
      out_wen_d    = 1'b0;
      out_data_d   = '0;
      skid_valid_d = 1'b0;
      skid_rd_d    = '0;
      skid_wen_d   = 1'b0;
      skid_data_d  = '0;
    end else if (out_free_c) begin
      if (skid_valid_q) begin
        // Older skid entry goes first; new input (if any) refills the skid
        out_valid_d  = 1'b1;
        out_rd_d     = skid_rd_q;
        out_wen_d    = skid_wen_q;
        out_data_d   = skid_data_q;
        skid_valid_d = in_xfer_c;
        if (in_xfer_c) begin
          skid_rd_d   = mem_rd_addr_i;
          skid_wen_d  = cap_wen_c;
          skid_data_d = cap_data_c;
        end
      end else if (in_xfer_c) begin
        out_valid_d = 1'b1;
        out_rd_d    = mem_rd_addr_i;
        out_wen_d   = cap_wen_c;
        out_data_d  = cap_data_c;
      end else begin
        // Drained with no replacement: data and rd hold
        out_valid_d = 1'b0;
        out_wen_d   = 1'b0;
      end
    end else if (in_xfer_c) begin
      skid_valid_d = 1'b1;
      skid_rd_d    = mem_rd_addr_i;
      skid_wen_d   = cap_wen_c;
      skid_data_d  = cap_data_c;
    end

    ready_d = ~skid_valid_d;

`ifdef MEM_WB_PERF_CNT_EN
    stall_cnt_d = stall_cnt_q + 32'(out_valid_q & ~wb_ready_i);
    flush_cnt_d = flush_cnt_q;
    if (flush_i) begin
      flush_cnt_d = flush_cnt_q + 32'(out_valid_q) + 32'(skid_valid_q);
    end
`endif
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_rd_q     <= '0;
      out_wen_q    <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_rd_q    <= '0;
      skid_wen_q   <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
`ifdef MEM_WB_PERF_CNT_EN
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      out_rd_q     <= out_rd_d;
      out_wen_q    <= out_wen_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_rd_q    <= skid_rd_d;
      skid_wen_q   <= skid_wen_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
`ifdef MEM_WB_PERF_CNT_EN
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
`endif
    end
  end

  assign mem_ready_o       = ready_q;
  assign wb_valid_o        = out_valid_q;
  assign wb_rd_addr_o      = out_rd_q;
  assign wb_reg_write_en_o = out_wen_q;
  assign wb_write_data_o   = out_data_q;
`ifdef MEM_WB_PERF_CNT_EN
  assign perf_stall_cnt_o  = stall_cnt_q;
  assign perf_flush_cnt_o  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench for mem_wb_pipe_reg: vector table for writeback formation,
// hand sequences for backpressure, drain and flush.
module tb_mem_wb_pipe_reg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush_i;
  logic            mem_valid_i;
  logic            mem_ready_o;
  logic [XLEN-1:0] mem_alu_result_i;
  logic [XLEN-1:0] mem_mem_read_data_i;
  logic [XLEN-1:0] mem_pc_plus_4_i;
  logic [RW-1:0]   mem_rd_addr_i;
  logic            mem_reg_write_en_i;
  logic [1:0]      mem_mem_to_reg_i;
  logic [2:0]      mem_load_funct3_i;
  logic            wb_ready_i;
  logic            wb_valid_o;
  logic [RW-1:0]   wb_rd_addr_o;
  logic            wb_reg_write_en_o;
  logic [XLEN-1:0] wb_write_data_o;
`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0]     perf_stall_cnt_o;
  logic [31:0]     perf_flush_cnt_o;
`endif

  mem_wb_pipe_reg #(.XLEN(XLEN), .REG_ADDR_W(RW), .RESERVED_SEL_WRITE(1'b0)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush_i             (flush_i),
    .mem_valid_i         (mem_valid_i),
    .mem_ready_o         (mem_ready_o),
    .mem_alu_result_i    (mem_alu_result_i),
    .mem_mem_read_data_i (mem_mem_read_data_i),
    .mem_pc_plus_4_i     (mem_pc_plus_4_i),
    .mem_rd_addr_i       (mem_rd_addr_i),
    .mem_reg_write_en_i  (mem_reg_write_en_i),
    .mem_mem_to_reg_i    (mem_mem_to_reg_i),
    .mem_load_funct3_i   (mem_load_funct3_i),
    .wb_ready_i          (wb_ready_i),
    .wb_valid_o          (wb_valid_o),
    .wb_rd_addr_o        (wb_rd_addr_o),
    .wb_reg_write_en_o   (wb_reg_write_en_o),
    .wb_write_data_o     (wb_write_data_o)
`ifdef MEM_WB_PERF_CNT_EN
    ,
    .perf_stall_cnt_o    (perf_stall_cnt_o),
    .perf_flush_cnt_o    (perf_flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        wr;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] exp_data;
    logic        exp_wen;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc4,
                       input logic [4:0] rd, input logic wr, input logic [1:0] sel,
                       input logic [2:0] f3);
    mem_valid_i         = 1'b1;
    mem_alu_result_i    = alu;
    mem_mem_read_data_i = rdata;
    mem_pc_plus_4_i     = pc4;
    mem_rd_addr_i       = rd;
    mem_reg_write_en_i  = wr;
    mem_mem_to_reg_i    = sel;
    mem_load_funct3_i   = f3;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] data,
                            input logic [4:0] rd, input logic wen);
    check({name, ".valid"}, 64'(wb_valid_o), 64'(v));
    check({name, ".data"},  64'(wb_write_data_o), 64'(data));
    check({name, ".rd"},    64'(wb_rd_addr_o), 64'(rd));
    check({name, ".wen"},   64'(wb_reg_write_en_o), 64'(wen));
  endtask

  localparam logic [31:0] RW_WORD = 32'hABCD80F4;

  initial begin
    //           alu           rdata    pc4       rd  wr sel    f3      exp_data      wen
    vecs[0]  = '{32'h0000000F, 32'h0,   32'h0,    3,  1, 2'b00, 3'b010, 32'h0000000F, 1};
    vecs[1]  = '{32'h00001001, RW_WORD, 32'h0,    5,  1, 2'b01, 3'b000, 32'hFFFFFF80, 1};
    vecs[2]  = '{32'h00001000, RW_WORD, 32'h0,    5,  1, 2'b01, 3'b100, 32'h000000F4, 1};
    vecs[3]  = '{32'h00001002, RW_WORD, 32'h0,    6,  1, 2'b01, 3'b101, 32'h0000ABCD, 1};
    vecs[4]  = '{32'h00001000, RW_WORD, 32'h0,    6,  1, 2'b01, 3'b001, 32'hFFFF80F4, 1};
    vecs[5]  = '{32'h00001000, RW_WORD, 32'h0,    7,  1, 2'b01, 3'b010, 32'hABCD80F4, 1};
    vecs[6]  = '{32'h00000000, 32'h0,   32'h2C,   1,  1, 2'b10, 3'b000, 32'h0000002C, 1};
    vecs[7]  = '{32'h00000000, 32'h0,   32'h2C,   0,  1, 2'b10, 3'b000, 32'h0000002C, 0};
    vecs[8]  = '{32'h00000055, 32'h0,   32'h0,    7,  1, 2'b11, 3'b000, 32'h00000000, 0};
    vecs[9]  = '{32'h00000077, 32'h0,   32'h0,    4,  0, 2'b00, 3'b000, 32'h00000077, 0};
    vecs[10] = '{32'h00001003, RW_WORD, 32'h0,    9,  1, 2'b01, 3'b000, 32'hFFFFFFAB, 1};
    vecs[11] = '{32'h00001003, RW_WORD, 32'h0,    9,  1, 2'b01, 3'b101, 32'h0000ABCD, 1};

    rst_n = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 3'b000);
    mem_valid_i = 1'b0;

    // Reset: two cycles low, outputs zero; ready one cycle after release
    step(); step();
    expect_out("reset", 1'b0, 32'h0, 5'd0, 1'b0);
    check("reset.ready", 64'(mem_ready_o), 64'd0);
    rst_n = 1'b1;
    step();
    check("post_reset.ready", 64'(mem_ready_o), 64'd1);
    check("post_reset.valid", 64'(wb_valid_o), 64'd0);

    // Back-to-back vectors at full throughput, one-cycle latency
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].alu, vecs[i].rdata, vecs[i].pc4, vecs[i].rd, vecs[i].wr,
            vecs[i].sel, vecs[i].f3);
      step();
      expect_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp_data, vecs[i].rd, vecs[i].exp_wen);
    end

    // Drain with no replacement: valid/wen drop, data and rd hold
    mem_valid_i = 1'b0;
    step();
    expect_out("drain", 1'b0, 32'h0000ABCD, 5'd9, 1'b0);

    // Backpressure: A captured, then B into skid while output holds, C waits
    drive(32'hA, 32'h0, 32'h0, 5'd10, 1'b1, 2'b00, 3'b000);
    step();
    expect_out("bp.A", 1'b1, 32'hA, 5'd10, 1'b1);
    wb_ready_i = 1'b0;
    drive(32'hB, 32'h0, 32'h0, 5'd11, 1'b1, 2'b00, 3'b000);
    step();
    expect_out("bp.holdA0", 1'b1, 32'hA, 5'd10, 1'b1);
    check("bp.ready0", 64'(mem_ready_o), 64'd0);
    drive(32'hC, 32'h0, 32'h0, 5'd13, 1'b1, 2'b00, 3'b000);
    for (int k = 1; k <= 2; k++) begin
      step();
      expect_out($sformatf("bp.holdA%0d", k), 1'b1, 32'hA, 5'd10, 1'b1);
      check($sformatf("bp.ready%0d", k), 64'(mem_ready_o), 64'd0);
    end
`ifdef MEM_WB_PERF_CNT_EN
    check("bp.stall_cnt", 64'(perf_stall_cnt_o), 64'd3);
`endif
    wb_ready_i = 1'b1;
    step();
    expect_out("bp.B", 1'b1, 32'hB, 5'd11, 1'b1);
    check("bp.ready_back", 64'(mem_ready_o), 64'd1);
    step();
    expect_out("bp.C", 1'b1, 32'hC, 5'd13, 1'b1);
    mem_valid_i = 1'b0;
    step();
    check("bp.empty", 64'(wb_valid_o), 64'd0);
`ifdef MEM_WB_PERF_CNT_EN
    check("bp.stall_final", 64'(perf_stall_cnt_o), 64'd3);
`endif

    // Flush with both entries full and a valid input presented
    wb_ready_i = 1'b0;
    drive(32'h111, 32'h0, 32'h0, 5'd2, 1'b1, 2'b00, 3'b000);
    step();
    drive(32'h222, 32'h0, 32'h0, 5'd3, 1'b1, 2'b00, 3'b000);
    step();
    check("fl.full_ready", 64'(mem_ready_o), 64'd0);
    drive(32'hEEEEEEEE, 32'h0, 32'h0, 5'd8, 1'b1, 2'b00, 3'b000);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    expect_out("flush", 1'b0, 32'h0, 5'd0, 1'b0);
    check("flush.ready", 64'(mem_ready_o), 64'd1);
`ifdef MEM_WB_PERF_CNT_EN
    check("flush.cnt", 64'(perf_flush_cnt_o), 64'd2);
`endif
    wb_ready_i = 1'b1;
    drive(32'hDDDDDDDD, 32'h0, 32'h0, 5'd12, 1'b1, 2'b00, 3'b000);
    step();
    expect_out("post_flush", 1'b1, 32'hDDDDDDDD, 5'd12, 1'b1);
    mem_valid_i = 1'b0;
    step();
    check("post_flush.empty", 64'(wb_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
